// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS memory-access path:
//   - byte_num_e  : access-size encoding produced by the instruction decoder
//   - mem_state_e : states of the mips_mem_access controller
//   - lane_shift  : bit offset of a big-endian byte lane inside a word
// ----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        BN_WORD      = 2'b00,
        BN_HALF      = 2'b01,
        BN_BYTE      = 2'b10,
        BN_UPPER_IMM = 2'b11   // LUI path; never a legal memory access size
    } byte_num_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } mem_state_e;

    // Big-endian: lane 00 is the most significant byte, so the shift is
    // (3 - lane) * 8, which for a 2-bit lane is simply ~lane * 8.
    function automatic logic [4:0] lane_shift(input logic [1:0] lane);
        return {~lane, 3'b000};
    endfunction

endpackage

// File: rtl/mips_lane_sel.sv
// ----------------------------------------------------------------------------
// mips_lane_sel
// Combinational big-endian lane logic for word / halfword / byte accesses.
//   rd_word_i : word returned by the data memory
//   wdata_i   : store data, sub-word value right-aligned in the low bits
//   bn_i      : access size
//   lane_i    : byte address bits [1:0]
//   load_o    : load result, zero-extended for sub-word sizes
//   merge_o   : rd_word_i with the addressed lane replaced by store data
// Halfwords select on lane_i[1] only and bytes on lane_i[1:0]; any alignment
// policy lives in the controller.
// ----------------------------------------------------------------------------
module mips_lane_sel
    import mips_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [31:0] wdata_i,
    input  byte_num_e   bn_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0] byte_sh;

    assign byte_sh = lane_shift(lane_i);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        load_o  = rd_word_i;
        merge_o = rd_word_i;
        case (bn_i)
            BN_WORD: begin
                load_o  = rd_word_i;
                merge_o = wdata_i;
            end
            BN_HALF: begin
                if (!lane_i[1]) begin
                    load_o  = {16'h0000, rd_word_i[31:16]};
                    merge_o = {wdata_i[15:0], rd_word_i[15:0]};
                end else begin
                    load_o  = {16'h0000, rd_word_i[15:0]};
                    merge_o = {rd_word_i[31:16], wdata_i[15:0]};
                end
            end
            BN_BYTE: begin
                load_o  = {24'h000000, 8'(rd_word_i >> byte_sh)};
                merge_o = (rd_word_i & ~(32'h0000_00FF << byte_sh))
                        | ({24'h000000, wdata_i[7:0]} << byte_sh);
            end
            default: begin
                // Upper-immediate never reaches the memory port.
                load_o  = rd_word_i;
                merge_o = rd_word_i;
            end
        endcase
    end

endmodule

// File: rtl/mips_mem_access.sv
// ----------------------------------------------------------------------------
// mips_mem_access
// Memory-side load/store controller between the datapath and a word-wide,
// ack-handshaked data memory. Big-endian word/halfword/byte accesses, loads
// zero-extended, sub-word stores done as read-modify-write.
//
// Parameters:
//   ACK_TIMEOUT : cycles a request may wait for mem_ack before it is aborted
// Build option:
//   MIPS_MEM_ALIGN_CHECK_EN : when defined, misaligned word/halfword accesses
//                             complete with error and never touch memory
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start               : request strobe, only sampled while busy is low
//   mem_read, mem_write : decoded load / store request
//   byte_number         : access size (see mips_pkg::byte_num_e)
//   addr, wdata         : byte address and store data from the datapath
//   busy                : high from accepted start through the done cycle
//   done, error         : completion pulse and its status
//   rdata               : load result, held until a later load completes
//   mem_req, mem_we     : memory request / write enable, held until mem_ack
//   mem_addr, mem_wdata : word address and full write word
//   mem_rdata, mem_ack  : memory read data and one-cycle acknowledge
// ----------------------------------------------------------------------------
module mips_mem_access
    import mips_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  byte_number,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    mem_state_e       state_q,     state_d;
    logic [29:0]      mem_addr_q,  mem_addr_d;
    logic [1:0]       lane_q,      lane_d;
    byte_num_e        bn_q,        bn_d;
    logic             load_q,      load_d;
    logic             err_q,       err_d;
    logic [31:0]      rdata_q,     rdata_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic        req_illegal;
    logic        req_misaligned;
    byte_num_e   bn_in;

    assign bn_in = byte_num_e'(byte_number);

    // mem_wdata_q holds the raw store data until the RMW read returns, so it
    // doubles as the merge source and no separate wdata register is needed.
    mips_lane_sel u_lane_sel (
        .rd_word_i (mem_rdata),
        .wdata_i   (mem_wdata_q),
        .bn_i      (bn_q),
        .lane_i    (lane_q),
        .load_o    (load_data),
        .merge_o   (merge_data)
    );

    assign req_illegal = (mem_read && mem_write)
                       || ((bn_in == BN_UPPER_IMM) && (mem_read || mem_write));

`ifdef MIPS_MEM_ALIGN_CHECK_EN
    assign req_misaligned = ((bn_in == BN_WORD) && (addr[1:0] != 2'b00))
                          || ((bn_in == BN_HALF) && addr[0]);
`else
    assign req_misaligned = 1'b0;
`endif

    // NOTE: combinational next-state logic uses blocking assignments; only
    // the clocked register block below uses non-blocking ones.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        lane_d      = lane_q;
        bn_d        = bn_q;
        load_d      = load_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mem_addr_d  = addr[31:2];
                    lane_d      = addr[1:0];
                    bn_d        = bn_in;
                    load_d      = mem_read;
                    mem_wdata_d = wdata;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    if (req_illegal || req_misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (!mem_read && !mem_write) begin
                        state_d = ST_DONE;
                    end else if (mem_read || (bn_in != BN_WORD)) begin
                        state_d = ST_RD;   // load, or read half of an RMW
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end

            ST_RD: begin
                if (mem_ack) begin
                    if (load_q) begin
                        rdata_d = load_data;
                        state_d = ST_DONE;
                    end else begin
                        mem_wdata_d = merge_data;
                        cnt_d       = '0;
                        state_d     = ST_WR;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WR: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            lane_q      <= '0;
            bn_q        <= BN_WORD;
            load_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            lane_q      <= lane_d;
            bn_q        <= bn_d;
            load_q      <= load_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign error     = done && err_q;
    assign mem_req   = (state_q == ST_RD) || (state_q == ST_WR);
    assign mem_we    = (state_q == ST_WR);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mips_mem_access.sv
// ----------------------------------------------------------------------------
// tb_mips_mem_access
// Directed vectors against mips_mem_access (ACK_TIMEOUT = 4) with a small
// behavioural memory. Expected completions go into a scoreboard queue when a
// request is issued; a monitor pops and compares on every done pulse.
// ----------------------------------------------------------------------------
module tb_mips_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  byte_number;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    mips_mem_access #(.ACK_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .byte_number (byte_number),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .rdata       (rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
        int          done_cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          ack_wait = 0;
    bit          no_ack = 1'b0;
    bit          req_seen = 1'b0;
    logic [31:0] last_wdata = '0;
    logic [31:0] mem [logic [29:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: ack after ack_wait idle request cycles, never when
    // no_ack is set. Driven on the falling edge so the DUT samples it next.
    initial begin
        int wcnt = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mem_req) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (!no_ack && wcnt >= ack_wait) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    last_wdata    = mem_wdata;
                end else begin
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                end
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end
    end

    // Monitor: compares each done pulse against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_req) req_seen = 1'b1;
            if (rst_n && done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
                    check({e.name, "_error"}, {31'd0, error}, {31'd0, e.err});
                    if (e.chk_rd) check({e.name, "_rdata"}, rdata, e.rdata);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        check({name, "_ctrl"}, {27'd0, busy, done, error, mem_req, mem_we}, 32'd0);
        check({name, "_rdata"}, rdata, 32'd0);
        check({name, "_mem_addr"}, {2'b00, mem_addr}, 32'd0);
        check({name, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    // Issue one request in the current (busy-low) cycle and wait, bounded,
    // until the controller is idle again.
    task automatic do_op(input string name, input bit rd, input bit wr,
                         input logic [1:0] bn, input logic [31:0] a,
                         input logic [31:0] wd, input bit exp_err,
                         input bit chk_rd, input logic [31:0] exp_rd,
                         input int lat);
        exp_t e;
        int   n;
        e.name = name; e.err = exp_err; e.chk_rd = chk_rd;
        e.rdata = exp_rd; e.done_cyc = cyc + lat;
        sb.push_back(e);
        req_seen    = 1'b0;
        mem_read    = rd;
        mem_write   = wr;
        byte_number = bn;
        addr        = a;
        wdata       = wd;
        start       = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            check({name, "_busy_timeout"}, 32'd1, 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        byte_number = 2'b00; addr = '0; wdata = '0;
        mem[30'h40] = 32'h1122_3344;   // 0x100
        mem[30'h41] = 32'h0000_0000;   // 0x104
        mem[30'h42] = 32'h5566_7788;   // 0x108
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Loads: zero-extended big-endian lanes, zero-wait ack.
        do_op("lbu_102", 1, 0, 2'b10, 32'h102, 0, 0, 1, 32'h0000_0033, 2);
        do_op("lhu_100", 1, 0, 2'b01, 32'h100, 0, 0, 1, 32'h0000_1122, 2);
        do_op("lbu_103", 1, 0, 2'b10, 32'h103, 0, 0, 1, 32'h0000_0044, 2);

        // Word store and readback.
        do_op("sw_104", 0, 1, 2'b00, 32'h104, 32'hDEAD_BEEF, 0, 0, 0, 2);
        check("sw_104_wdata", last_wdata, 32'hDEAD_BEEF);
        do_op("lw_104", 1, 0, 2'b00, 32'h104, 0, 0, 1, 32'hDEAD_BEEF, 2);

        // Sub-word stores: RD then WR, merged word written.
        do_op("sb_101", 0, 1, 2'b10, 32'h101, 32'h0000_00AB, 0, 0, 0, 3);
        check("sb_101_wdata", last_wdata, 32'h11AB_3344);
        do_op("sh_102", 0, 1, 2'b01, 32'h102, 32'h1234_CAFE, 0, 0, 0, 3);
        check("sh_102_wdata", last_wdata, 32'h11AB_CAFE);
        do_op("lhu_102", 1, 0, 2'b01, 32'h102, 0, 0, 1, 32'h0000_CAFE, 2);

        // Illegal combinations and no-op: done next cycle, no memory access.
        do_op("rd_wr", 1, 1, 2'b00, 32'h100, 0, 1, 0, 0, 1);
        check("rd_wr_no_req", {31'd0, req_seen}, 32'd0);
        do_op("bn11_rd", 1, 0, 2'b11, 32'h100, 0, 1, 0, 0, 1);
        check("bn11_no_req", {31'd0, req_seen}, 32'd0);
        do_op("noop", 0, 0, 2'b00, 32'h100, 0, 0, 0, 0, 1);
        check("noop_no_req", {31'd0, req_seen}, 32'd0);

        // Two wait cycles on the ack add two cycles.
        ack_wait = 2;
        do_op("lw_wait2", 1, 0, 2'b00, 32'h100, 0, 0, 1, 32'h11AB_CAFE, 4);
        ack_wait = 0;

        // Timeout: request held for 4 cycles, then done with error.
        no_ack = 1'b1;
        do_op("lw_tmo", 1, 0, 2'b00, 32'h100, 0, 1, 0, 0, 5);
        do_op("sw_tmo", 0, 1, 2'b00, 32'h108, 32'hFFFF_0000, 1, 0, 0, 5);
        no_ack = 1'b0;
        do_op("lw_108", 1, 0, 2'b00, 32'h108, 0, 0, 1, 32'h5566_7788, 2);

        // Misaligned word load.
`ifdef MIPS_MEM_ALIGN_CHECK_EN
        do_op("lw_102", 1, 0, 2'b00, 32'h102, 0, 1, 0, 0, 1);
        check("lw_102_no_req", {31'd0, req_seen}, 32'd0);
`else
        do_op("lw_102", 1, 0, 2'b00, 32'h102, 0, 0, 1, 32'h11AB_CAFE, 2);
`endif

        // Reset pulsed while a read is outstanding.
        no_ack      = 1'b1;
        mem_read    = 1'b1;
        byte_number = 2'b00;
        addr        = 32'h104;
        start       = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        mem_read = 1'b0;
        @(negedge clk);
        check("rd_pending_req", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n  = 1'b1;
        no_ack = 1'b0;
        @(negedge clk);
        do_op("lw_after_rst", 1, 0, 2'b00, 32'h104, 0, 0, 1, 32'hDEAD_BEEF, 2);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
